stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter PRESCALE, default 4, clk cycles per count tick; legal range 1..65535.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 r  input  1  reset, synchronous, active-high.
REQ-004 start_stop  input  1  one-cycle pulse; toggles run/pause.
REQ-005 clr  input  1  one-cycle pulse; returns to idle with count zero.
REQ-006 lap  input  1  one-cycle pulse; toggles display freeze.
REQ-007 q0, q1, q2, q3  output  4 each  displayed BCD digits; q0 = units, q3 = thousands.
REQ-008 running  output  1  high while in RUN.
REQ-009 ovf  output  1  sticky; set on attempted count past 9999.
REQ-010 lap_hold  output  1  high while the display is frozen.

Function
REQ-011 States SHALL be IDLE, RUN, PAUSE, OVF; the state register, prescaler, count and ovf SHALL be registered.
REQ-012 start_stop SHALL move IDLE->RUN, RUN->PAUSE and PAUSE->RUN, and SHALL be ignored in OVF.
REQ-013 clr SHALL force IDLE from any state: count 0000, prescaler 0, ovf 0, lap_hold 0.
REQ-014 Simultaneous clr and start_stop SHALL act as clr alone.
REQ-015 The prescaler SHALL count 0..PRESCALE-1 only in RUN and hold its value in PAUSE.
REQ-016 A tick SHALL occur when the prescaler is at PRESCALE-1 in RUN; the prescaler then wraps to 0.
REQ-017 The first increment after IDLE->RUN SHALL land on the PRESCALE-th rising edge after the edge that entered RUN.
REQ-018 On a tick the 4-digit count SHALL add 1 in BCD: a digit at 9 wraps to 0 and carries into the next digit in the same cycle.
REQ-019 No digit SHALL ever hold 10..15.
REQ-020 A tick at count 9999 SHALL leave the count at 9999, set ovf, and enter OVF (running=0).
REQ-021 start_stop in the tick cycle SHALL let the tick complete; the state changes to PAUSE on the same edge.
REQ-022 Without a lap hold, q0..q3 SHALL be the live count registers (zero added latency).
REQ-023 running SHALL be a pure decode of state==RUN.

Reset
REQ-024 r=1 SHALL take effect at the next edge, override every other input, and give state IDLE, count 0000, prescaler 0, ovf 0, lap_hold 0, running 0.
REQ-025 r asserted mid-RUN or mid-tick SHALL discard the pending increment.

Configuration
REQ-026 Macro STOPWATCH_LAP_EN defined: lap in RUN or PAUSE with lap_hold=0 SHALL snapshot the pre-edge count and set lap_hold.
REQ-027 While lap_hold=1, q0..q3 SHALL show the snapshot; the live count keeps advancing.
REQ-028 A lap pulse while lap_hold=1 SHALL clear lap_hold.
REQ-029 lap in IDLE or OVF SHALL be ignored.
REQ-030 Macro undefined: lap SHALL be ignored, lap_hold tied 0, no snapshot registers present.

Structure
REQ-031 Package stopwatch_pkg SHALL hold the state enum, the BCD digit width (4) and the terminal digit value (9).
REQ-032 Sub-module bcd_digit SHALL implement one decade digit with inputs clk, r, ce and outputs q, tc, ceo (ceo = ce & tc).
REQ-033 Four bcd_digit instances SHALL be chained ceo->ce.
REQ-034 stopwatch_ctrl SHALL own the FSM, the prescaler, the 9999 saturation logic and the lap logic.

Verification (PRESCALE=2)
REQ-035 r, then start_stop, then 20 idle cycles -> count 0010, running=1, ovf=0.
REQ-036 Count 0199, tick -> 0200 in one edge (double carry).
REQ-037 Pause 6 cycles at 0200 -> count 0200 held; start_stop -> 0201 exactly 2 edges later.
REQ-038 Count 9999, tick -> q=9999, ovf=1, running=0; start_stop ignored; clr -> 0000, ovf=0, IDLE.
REQ-039 STOPWATCH_LAP_EN: lap at 0042 during RUN, 10 more cycles -> q shows 0042, lap_hold=1; second lap -> q shows 0047, lap_hold=0.
REQ-040 clr and start_stop together in RUN -> IDLE, 0000, running=0; r mid-tick -> 0000, no increment.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller: FSM states,
// BCD digit geometry and prescaler width.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVF   = 2'd3
    } sw_state_e;

    localparam int DIGIT_W   = 4;
    localparam int NUM_DIG   = 4;
    localparam int PRESC_W   = 16;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    // True when a digit sits at its terminal value and will wrap on the next enable.
    function automatic logic digit_is_term(input logic [DIGIT_W-1:0] d);
        return (d == DIGIT_MAX);
    endfunction

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One decade counter digit (module bcd_digit): counts 0..9 on ce and
// produces a carry enable for the next decade.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic               clk,
    input  logic               r,
    input  logic               ce,
    output logic [DIGIT_W-1:0] q,
    output logic               tc,
    output logic               ceo
);

    assign tc  = digit_is_term(q);
    assign ceo = ce & tc;

    // Decade register; any out-of-range value is folded back to zero on the next enable.
    always_ff @(posedge clk) begin
        if (r) begin
            q <= 4'd0;
        end else if (ce) begin
            if (q >= DIGIT_MAX) begin
                q <= 4'd0;
            end else begin
                q <= q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Four-digit BCD stopwatch: run/pause FSM, tick prescaler, 9999 saturation
// and an optional lap display freeze enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic       clk,
    input  logic       r,
    input  logic       start_stop,
    input  logic       clr,
    input  logic       lap,
    output logic [3:0] q0,
    output logic [3:0] q1,
    output logic [3:0] q2,
    output logic [3:0] q3,
    output logic       running,
    output logic       ovf,
    output logic       lap_hold
);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);

    sw_state_e            state_r;
    logic [PRESC_W-1:0]   presc_r;
    logic                 ovf_r;

    logic                 tick_s;
    logic                 all_nines_s;
    logic                 digit_rst_s;
    logic [NUM_DIG-1:0]   ce_s;
    logic [NUM_DIG-1:0]   ceo_s;
    logic [NUM_DIG-1:0]   tc_s;
    logic [DIGIT_W-1:0]   dig_q_s [NUM_DIG];
    logic [15:0]          live_s;
    logic [15:0]          disp_s;
    logic                 unused_ceo_s;

    assign tick_s      = (state_r == ST_RUN) && (presc_r == PRESC_MAX);
    assign all_nines_s = &tc_s;
    assign digit_rst_s = r | clr;
    // Saturate at 9999: the tick is swallowed instead of wrapping the count.
    assign ce_s[0]     = tick_s & ~all_nines_s;
    assign unused_ceo_s = ceo_s[NUM_DIG-1];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIG; gi++) begin : g_digit
            if (gi > 0) begin : g_chain
                assign ce_s[gi] = ceo_s[gi-1];
            end
            bcd_digit u_digit (
                .clk (clk),
                .r   (digit_rst_s),
                .ce  (ce_s[gi]),
                .q   (dig_q_s[gi]),
                .tc  (tc_s[gi]),
                .ceo (ceo_s[gi])
            );
        end
    endgenerate

    assign live_s = {dig_q_s[3], dig_q_s[2], dig_q_s[1], dig_q_s[0]};

    // Run/pause/overflow FSM together with the prescaler it gates.
    always_ff @(posedge clk) begin
        if (r || clr) begin
            state_r <= ST_IDLE;
            presc_r <= 16'd0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_stop) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (tick_s) begin
                        presc_r <= 16'd0;
                    end else begin
                        presc_r <= presc_r + 16'd1;
                    end
                    // Overflow outranks a coincident pause request.
                    if (tick_s && all_nines_s) begin
                        state_r <= ST_OVF;
                        ovf_r   <= 1'b1;
                    end else if (start_stop) begin
                        state_r <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (start_stop) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_OVF: begin
                    state_r <= ST_OVF;
                end
                default: begin
                    state_r <= ST_IDLE;
                    presc_r <= 16'd0;
                    ovf_r   <= 1'b0;
                end
            endcase
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic        lap_hold_r;
    logic [15:0] snap_r;

    // Lap toggle: first pulse captures the pre-edge count, second releases the display.
    always_ff @(posedge clk) begin
        if (r || clr) begin
            lap_hold_r <= 1'b0;
            snap_r     <= 16'd0;
        end else if (lap && ((state_r == ST_RUN) || (state_r == ST_PAUSE))) begin
            if (lap_hold_r) begin
                lap_hold_r <= 1'b0;
            end else begin
                lap_hold_r <= 1'b1;
                snap_r     <= live_s;
            end
        end
    end

    // Frozen snapshot while held, otherwise the live digits.
    always_comb begin
        disp_s = live_s;
        if (lap_hold_r) begin
            disp_s = snap_r;
        end else begin
            disp_s = live_s;
        end
    end

    assign lap_hold = lap_hold_r;
`else
    logic unused_lap_s;

    assign unused_lap_s = lap;
    assign disp_s       = live_s;
    assign lap_hold     = 1'b0;
`endif

    assign q0      = disp_s[3:0];
    assign q1      = disp_s[7:4];
    assign q2      = disp_s[11:8];
    assign q3      = disp_s[15:12];
    assign running = (state_r == ST_RUN);
    assign ovf     = ovf_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (PRESCALE=2): directed vector table,
// then random pulses checked every cycle against a decimal-count reference model.
module tb_stopwatch_ctrl;

    localparam int P = 2;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_OVF = 3;

    logic clk = 1'b0;
    logic r = 1'b0, start_stop = 1'b0, clr = 1'b0, lap = 1'b0;
    logic [3:0] q0, q1, q2, q3;
    logic running, ovf, lap_hold;

    int total = 0;
    int bad = 0;

    // Reference model state: plain decimal count, cycle counter, flags.
    int m_mode = M_IDLE, m_pre = 0, m_cnt = 0, m_snap = 0;
    bit m_ovf = 1'b0, m_lh = 1'b0;

    typedef struct {
        logic r, ss, clr, lap;
        int   n;
        int   exp_cnt;
        logic exp_run, exp_ovf, exp_lh;
    } vec_t;

    vec_t tbl[$];

    stopwatch_ctrl #(.PRESCALE(P)) dut (
        .clk(clk), .r(r), .start_stop(start_stop), .clr(clr), .lap(lap),
        .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .running(running), .ovf(ovf), .lap_hold(lap_hold)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit i_r, input bit i_ss, input bit i_clr, input bit i_lap);
        int pre_mode;
        bit tick;
        if (i_r || i_clr) begin
            m_mode = M_IDLE; m_pre = 0; m_cnt = 0; m_ovf = 1'b0; m_lh = 1'b0;
            return;
        end
        pre_mode = m_mode;
        if (LAP_EN && i_lap && (pre_mode == M_RUN || pre_mode == M_PAUSE)) begin
            if (m_lh) m_lh = 1'b0;
            else begin m_snap = m_cnt; m_lh = 1'b1; end
        end
        if (pre_mode == M_RUN) begin
            tick = (m_pre == P - 1);
            m_pre = tick ? 0 : m_pre + 1;
            if (tick && m_cnt == 9999) begin
                m_ovf = 1'b1;
                m_mode = M_OVF;
            end else begin
                if (tick) m_cnt++;
                if (i_ss) m_mode = M_PAUSE;
            end
        end else if ((pre_mode == M_IDLE || pre_mode == M_PAUSE) && i_ss) begin
            m_mode = M_RUN;
        end
    endtask

    // One clock edge with the given pulses, then model update and per-cycle comparison.
    task automatic step(input bit i_r, input bit i_ss, input bit i_clr, input bit i_lap);
        r = i_r; start_stop = i_ss; clr = i_clr; lap = i_lap;
        @(posedge clk);
        #1;
        model_step(i_r, i_ss, i_clr, i_lap);
        r = 1'b0; start_stop = 1'b0; clr = 1'b0; lap = 1'b0;
        check("model_q", {16'd0, q3, q2, q1, q0}, {16'd0, to_bcd(m_lh ? m_snap : m_cnt)});
        check("model_flags", {29'd0, running, ovf, lap_hold}, {29'd0, m_mode == M_RUN, m_ovf, m_lh});
    endtask

    task automatic add(input bit vr, input bit vss, input bit vclr, input bit vlap, input int n,
                       input int ec, input bit er, input bit eo, input bit el);
        vec_t v;
        v.r = vr; v.ss = vss; v.clr = vclr; v.lap = vlap; v.n = n;
        v.exp_cnt = ec; v.exp_run = er; v.exp_ovf = eo; v.exp_lh = el;
        tbl.push_back(v);
    endtask

    initial begin
        //   r  ss clr lap  n      count run ovf lh
        add(1, 0, 0, 0, 1,     0,    0, 0, 0);   // reset state
        add(0, 1, 0, 0, 21,    10,   1, 0, 0);   // start + 20 cycles
        add(0, 0, 0, 0, 379,   199,  1, 0, 0);   // reach 0199, tick pending
        add(0, 1, 0, 0, 1,     200,  0, 0, 0);   // double carry + pause in tick cycle
        add(0, 0, 0, 0, 6,     200,  0, 0, 0);   // paused: held
        add(0, 1, 0, 0, 1,     200,  1, 0, 0);   // resume
        add(0, 0, 0, 0, 1,     200,  1, 0, 0);
        add(0, 0, 0, 0, 1,     201,  1, 0, 0);   // increment 2 edges after resume
        add(0, 1, 1, 0, 1,     0,    0, 0, 0);   // clr wins over start_stop
        add(0, 1, 0, 0, 1,     0,    1, 0, 0);
        add(0, 0, 0, 0, 1,     0,    1, 0, 0);   // prescaler now at terminal
        add(1, 0, 0, 0, 1,     0,    0, 0, 0);   // reset mid-tick
        add(0, 0, 0, 0, 3,     0,    0, 0, 0);   // no late increment
        add(0, 1, 0, 0, 1,     0,    1, 0, 0);
        add(0, 0, 0, 0, 84,    42,   1, 0, 0);
        add(0, 0, 0, 1, 1,     42,   1, 0, LAP_EN);
        add(0, 0, 0, 0, 9,     LAP_EN ? 42 : 47, 1, 0, LAP_EN);
        add(0, 0, 0, 1, 1,     47,   1, 0, 0);   // second lap releases
        add(0, 0, 1, 0, 1,     0,    0, 0, 0);
        add(0, 1, 0, 0, 1,     0,    1, 0, 0);
        add(0, 0, 0, 0, 19998, 9999, 1, 0, 0);
        add(0, 0, 0, 0, 1,     9999, 1, 0, 0);
        add(0, 0, 0, 0, 1,     9999, 0, 1, 0);   // saturate into overflow
        add(0, 1, 0, 0, 1,     9999, 0, 1, 0);   // start_stop ignored
        add(0, 0, 0, 0, 4,     9999, 0, 1, 0);
        add(0, 0, 1, 0, 1,     0,    0, 0, 0);   // clr leaves overflow
        add(0, 1, 0, 0, 1,     0,    1, 0, 0);   // back in IDLE -> RUN

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].ss, tbl[i].clr, tbl[i].lap);
            for (int k = 1; k < tbl[i].n; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("vec%0d_q", i), {16'd0, q3, q2, q1, q0}, {16'd0, to_bcd(tbl[i].exp_cnt)});
            check($sformatf("vec%0d_flags", i), {29'd0, running, ovf, lap_hold},
                  {29'd0, tbl[i].exp_run, tbl[i].exp_ovf, tbl[i].exp_lh});
        end

        for (int c = 0; c < 4000; c++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 63) == 0, $urandom_range(0, 9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
